// File: rtl/alu_mc.sv
// alu_mc: multi-cycle W-bit ALU with valid/ready handshake, iterative shifts and shift-add multiply
module alu_mc #(
  parameter int W    = 8,
  parameter int IMMW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_cmd,
  input  logic [W-1:0]    inA,
  input  logic [W-1:0]    inB,
  input  logic [IMMW-1:0] imm,
  input  logic            sc_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    rslt,
  output logic [W-1:0]    rslt_hi,
  output logic            sc_o,
  output logic            zero,
  output logic            pari,
  output logic            err
);
  localparam int NW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_n;
  logic [3:0]    op;
  logic          sc;
  logic [W-1:0]  m;
  logic [NW-1:0] cnt, cnt_n, n;
  logic [W-1:0]  lo_n, hi_n;
  logic          c_n, err_n, acc, multi, load;
  logic [W:0]    sum;
  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE) | (out_valid & out_ready);
  assign acc       = in_valid & in_ready;
  assign n         = (inB[NW-1:0] > NW'(W)) ? NW'(W) : inB[NW-1:0];
  assign multi     = (((alu_cmd == 4'h1) || (alu_cmd == 4'h2)) && (n != '0)) || (alu_cmd == 4'h5);
  // the running product lives in {rslt_hi,rslt}; rslt doubles as the multiplier being consumed
  assign sum       = {1'b0, rslt_hi} + (rslt[0] ? {1'b0, m} : '0);
  // next state plus next datapath values for an accept or one iterative step
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lo_n    = rslt;
    hi_n    = rslt_hi;
    c_n     = sc_o;
    err_n   = err;
    load    = 1'b0;
    if (acc) begin
      load    = 1'b1;
      state_n = multi ? RUN : DONE;
      cnt_n   = (alu_cmd == 4'h5) ? NW'(W) : n;
      lo_n    = inA;
      hi_n    = '0;
      c_n     = 1'b0;
      err_n   = 1'b0;
      case (alu_cmd)
        4'h0, 4'h1, 4'h2: if (alu_cmd == 4'h0) {c_n, lo_n} = {1'b0, inA} + {1'b0, inB} + (W+1)'(sc_i);
        4'h3:    lo_n = ~(inA & inB);
        4'h4:    {c_n, lo_n} = {1'b0, inA} - {1'b0, inB} + (W+1)'(sc_i);
        4'h5:    lo_n = inB;
        4'h7:    {c_n, lo_n} = {1'b0, inB} + (W+1)'(imm) + (W+1)'(sc_i);
        default: begin
          lo_n  = '0;
          err_n = 1'b1;
        end
      endcase
    end else if (state == RUN) begin
      load    = 1'b1;
      cnt_n   = cnt - NW'(1);
      state_n = (cnt == NW'(1)) ? DONE : RUN;
      case (op)
        4'h1:    {c_n, lo_n} = {rslt, sc};
        4'h2:    {lo_n, c_n} = {sc, rslt};
        default: begin
          {hi_n, lo_n} = {sum, rslt[W-1:1]};
          c_n = |hi_n;
        end
      endcase
    end else if (out_valid && out_ready) begin
      state_n = IDLE;
    end
  end
  // state, captured operands and registered result/flags; results hold whenever load is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      sc      <= 1'b0;
      m       <= '0;
      rslt    <= '0;
      rslt_hi <= '0;
      sc_o    <= 1'b0;
      zero    <= 1'b0;
      pari    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (acc) begin
        op <= alu_cmd;
        sc <= sc_i;
        m  <= inA;
      end
      if (load) begin
        rslt    <= lo_n;
        rslt_hi <= hi_n;
        sc_o    <= c_n;
        err     <= err_n;
        zero    <= ~|{hi_n, lo_n};
        pari    <= ^lo_n;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc at W=8
module tb_alu_mc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_cmd = '0;
  logic [7:0] inA = '0;
  logic [7:0] inB = '0;
  logic [3:0] imm = '0;
  logic       sc_i = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] rslt, rslt_hi;
  logic       sc_o, zero, pari, err;
  int checks = 0;
  int errors = 0;

  alu_mc #(.W(8), .IMMW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .imm(imm), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt), .rslt_hi(rslt_hi),
    .sc_o(sc_o), .zero(zero), .pari(pari), .err(err)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] i, input logic s);
    @(negedge clk);
    alu_cmd = c; inA = a; inB = b; imm = i; sc_i = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, rslt, rslt_hi, sc_o, zero, pari, err} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset: rdy/vld/rslt/hi/sc/z/p/err = %b %b %h %h %b%b%b%b", in_ready, out_valid, rslt, rslt_hi, sc_o, zero, pari, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat;
    out_ready = 1'b1;
    issue(4'h0, 8'hF0, 8'h20, 4'h0, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
    checks++;
    if ({rslt, sc_o, zero, pari} !== {8'h11, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add: rslt=%h sc=%b z=%b p=%b expected 11 1 0 0", rslt, sc_o, zero, pari);
    end
  endtask

  task automatic test_shl;
    out_ready = 1'b1;
    issue(4'h1, 8'h81, 8'h03, 4'h0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL shl_busy cycle %0d: in_ready=%b out_valid=%b expected 0 0", i, in_ready, out_valid);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, rslt, sc_o} !== {1'b1, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL shl: vld=%b rslt=%h sc=%b expected 1 0f 0", out_valid, rslt, sc_o);
    end
  endtask

  task automatic test_mul;
    int lat;
    issue(4'h5, 8'hFF, 8'hFF, 4'h0, 1'b0);
    out_ready = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL mul_latency: got %0d expected 9", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, rslt_hi, rslt, sc_o, zero, pari, err} !== {1'b1, 1'b0, 8'hFE, 8'h01, 4'b1010}) begin
        errors++;
        $display("FAIL mul_hold %0d: vld=%b rdy=%b hi=%h lo=%h sc/z/p/err=%b%b%b%b expected 1 0 fe 01 1010",
                 i, out_valid, in_ready, rslt_hi, rslt, sc_o, zero, pari, err);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_release: out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    @(negedge clk);
    alu_cmd = 4'h3; inA = 8'hFF; inB = 8'hFF; sc_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, rslt, zero, sc_o} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_nand: vld=%b rdy=%b rslt=%h z=%b sc=%b expected 1 1 00 1 0", out_valid, in_ready, rslt, zero, sc_o);
    end
    alu_cmd = 4'h4; inA = 8'h05; inB = 8'h05; sc_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, rslt, zero, sc_o} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_sub: vld=%b rslt=%h z=%b sc=%b expected 1 00 1 0", out_valid, rslt, zero, sc_o);
    end
    alu_cmd = 4'h4; inA = 8'h03; inB = 8'h05; sc_i = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, rslt, zero, sc_o, pari} !== {1'b1, 8'hFE, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_sub_borrow: vld=%b rslt=%h z=%b sc=%b p=%b expected 1 fe 0 1 1", out_valid, rslt, zero, sc_o, pari);
    end
  endtask

  task automatic test_shr_err;
    int lat;
    out_ready = 1'b1;
    issue(4'h2, 8'hA5, 8'h0F, 4'h0, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL shr_latency: got %0d expected 9", lat); end
    checks++;
    if ({rslt, sc_o, zero, err} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL shr: rslt=%h sc=%b z=%b err=%b expected 00 1 1 0", rslt, sc_o, zero, err);
    end
    issue(4'hF, 8'h55, 8'h33, 4'h0, 1'b1);
    wait_valid(lat);
    checks++;
    if ({lat == 1, err, rslt, rslt_hi, sc_o} !== {1'b1, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL err_op: lat=%0d err=%b rslt=%h hi=%h sc=%b expected 1 1 00 00 0", lat, err, rslt, rslt_hi, sc_o);
    end
    issue(4'h0, 8'h01, 8'h01, 4'h0, 1'b0);
    checks++;
    if ({out_valid, err, rslt} !== {1'b1, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL err_clear: vld=%b err=%b rslt=%h expected 1 0 02", out_valid, err, rslt);
    end
  endtask

  task automatic test_abort;
    int lat;
    out_ready = 1'b1;
    issue(4'h5, 8'h03, 8'h05, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, rslt, rslt_hi} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL abort_reset: vld=%b rdy=%b rslt=%h hi=%h expected 0 1 00 00", out_valid, in_ready, rslt, rslt_hi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    alu_cmd = 4'h7; inA = 8'hAA; inB = 8'h10; imm = 4'hF; sc_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL addi_latency: got %0d expected 1", lat); end
    checks++;
    if ({rslt, rslt_hi, sc_o, zero, pari} !== {8'h1F, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL addi: rslt=%h hi=%h sc=%b z=%b p=%b expected 1f 00 0 0 1", rslt, rslt_hi, sc_o, zero, pari);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_shl;
    test_mul;
    test_back_to_back;
    test_shr_err;
    test_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the processor datapath. It generalises the 8-bit combinational ALU in three ways: it works at width `W`, it uses a valid/ready handshake, and it supports multi-bit iterative shifts and a shift-add unsigned multiply. The block sits between the register-file read stage and writeback. Results and flags are registered and held until the consumer accepts them.

## Interface
Parameters:
- `W`, 8: datapath width, W ≥ 4.
- `IMMW`, 4: immediate width, IMMW ≤ W, zero-extended.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: the block accepts the offered operation this cycle.
- `alu_cmd` in 4: opcode.
- `inA` in W: operand A.
- `inB` in W: operand B.
- `imm` in IMMW: immediate operand.
- `sc_i` in 1: carry in.
- `out_valid` out 1: the result is held and valid.
- `out_ready` in 1: the consumer takes the result.
- `rslt` out W: result, or the low word for MUL.
- `rslt_hi` out W: high word for MUL, 0 for all other ops.
- `sc_o` out 1: carry out.
- `zero` out 1: result is zero.
- `pari` out 1: XOR reduction of `rslt`.
- `err` out 1: the opcode was undefined.

## Operation
- Accept occurs when `in_valid && in_ready`. The operands, `sc_i` and `imm` are captured on that edge. Later changes to the inputs have no effect on the operation in flight.
- Opcodes:
  - 0000 ADD: `{sc_o,rslt} = A + B + sc_i`, computed at W+1 bits.
  - 0001 SHL: shift A left by n. `sc_i` enters the LSB on every step. `sc_o` is the last bit shifted out of the MSB.
  - 0010 SHR: mirror of SHL. `sc_i` enters the MSB on every step. `sc_o` is the last bit shifted out of the LSB.
  - 0011 NAND: `rslt = ~(A & B)`, `sc_o = 0`.
  - 0100 SUB: `{sc_o,rslt} = A - B + sc_i`, computed modulo 2^(W+1).
  - 0101 MUL: unsigned product, `{rslt_hi,rslt} = A * B`. Uses W shift-add iterations. `sc_o = |rslt_hi`.
  - 0111 ADDI: `{sc_o,rslt} = B + zext(imm) + sc_i`.
  - All other opcodes: `rslt = 0`, `sc_o = 0`, `err = 1`. These are single-cycle.
- Shift amount n is `inB[$clog2(W):0]`. Any value greater than W saturates to W. When n = 0, the result is A, `sc_o = 0`, and the op is single-cycle.
- Flags:
  - `zero` is set when `rslt == 0`. For MUL it also requires `rslt_hi == 0`.
  - `pari = ^rslt`.
  - Flags are registered together with `rslt`.
- State machine:
  - IDLE: `in_ready = 1`.
    - Accepting a single-cycle op goes to DONE.
    - Accepting SHL or SHR with n ≥ 1 goes to RUN with `cnt = n`.
    - Accepting MUL goes to RUN with `cnt = W`.
  - RUN: performs one shift or add-shift step per cycle and decrements `cnt`. When `cnt` reaches 1 on this step, the next state is DONE. `in_ready = 0`.
  - DONE: `out_valid = 1`.
    - With `out_ready` high and `in_valid` low, go to IDLE.
    - With both `out_ready` and `in_valid` high, accept a new op in the same cycle (back-to-back). `in_ready = out_ready` in this state.
    - With `out_ready` low, hold all outputs stable.
- `in_ready` is combinational from the state and `out_ready` only. It never depends on `in_valid`.

## Timing
- Reset values: state IDLE, `in_ready = 1`, `out_valid = 0`. `rslt`, `rslt_hi`, `sc_o`, `zero`, `pari` and `err` are all 0.
- Asserting `rst_n` low mid-operation aborts the op immediately. No `out_valid` is produced for it. The first edge after release already accepts.
- Latency, counted from the accept edge to the first cycle `out_valid` is high:
  - Single-cycle ops: 1 cycle.
  - SHL/SHR: n + 1 cycles.
  - MUL: W + 1 cycles.
- Throughput: one single-cycle op per clock when `out_ready` stays high, using the DONE→DONE accept path.
- Outputs remain stable for every cycle that `out_valid && !out_ready` holds.
- `err` is only meaningful while `out_valid` is high. It clears on the next accept.

## Test plan
- Reset, then ADD with A=0xF0, B=0x20, `sc_i=1` → one cycle later: `rslt = 0x11`, `sc_o = 1`, `zero = 0`, `pari = 0`.
- SHL with A=0x81, B=3, `sc_i=1`, W=8 → `out_valid` 4 cycles after accept. `rslt = 0x0F`, `sc_o = 0`. `in_ready` is low for cycles 1–3.
- MUL with A=0xFF, B=0xFF, W=8 → `out_valid` 9 cycles after accept. `rslt_hi = 0xFE`, `rslt = 0x01`, `sc_o = 1`. Also hold `out_ready` low for 5 cycles and confirm all outputs stay stable.
- Back-to-back NAND(0xFF, 0xFF) then SUB(0x05, 0x05, `sc_i=0`) with `out_ready` tied high → results on consecutive cycles:
  - NAND: `rslt = 0x00`, `zero = 1`.
  - SUB: `rslt = 0x00`, `zero = 1`, `sc_o = 0`.
- SHR with B=0x0F (n saturates to 8), A=0xA5, `sc_i=0` → `rslt = 0x00` after 9 cycles, `sc_o = 1`. Then opcode 1111 → `err = 1`, `rslt = 0`.
- Assert `rst_n` low on cycle 4 of a MUL → `out_valid` never rises for that op. After release, ADDI with B=0x10, imm=0xF, `sc_i=0` returns `rslt = 0x1F` one cycle after accept.
